ex_alu_unit: RTL and testbench

//  Execute-stage ALU for the 5-stage pipeline. Parametrised successor of the combinational ALU control decoder.
//  - Decodes aluOp/funCode and computes the result in one block.
//  - Registers the result behind a valid/ready handshake.
//  - Adds an iterative multi-cycle multiply that stalls the stage; adds flush support.

---
 rtl/ex_alu_unit_pkg.sv | 62 ++++++
 rtl/alu_mul_iter.sv | 41 ++++
 rtl/ex_alu_unit.sv | 128 ++++++++++++
 tb/tb_ex_alu_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_unit_pkg.sv
// Shared codes for the execute-stage ALU: aluOp/funCode encodings, internal
// function enum, FSM states and the op decoder.
package ex_alu_unit_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;

  localparam logic [3:0] FC_ADD = 4'b0000;
  localparam logic [3:0] FC_SUB = 4'b0001;
  localparam logic [3:0] FC_SLT = 4'b0010;
  localparam logic [3:0] FC_AND = 4'b0100;
  localparam logic [3:0] FC_OR  = 4'b0101;
  localparam logic [3:0] FC_XOR = 4'b0110;
  localparam logic [3:0] FC_SLL = 4'b1000;
  localparam logic [3:0] FC_SRL = 4'b1001;
  localparam logic [3:0] FC_MUL = 4'b1100;

  typedef enum logic [3:0] {
    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT,
    FN_SLL, FN_SRL, FN_PASSB, FN_MUL, FN_ILL
  } aluFn_e;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  // MUL decodes as illegal when the multiplier is not built.
  function automatic aluFn_e decodeFn(input logic [2:0] aluOp,
                                      input logic [3:0] funCode,
                                      input logic mulEn);
    aluFn_e fn;
    fn = FN_ILL;
    case (aluOp)
      OP_RTYPE: begin
        case (funCode)
          FC_ADD:  fn = FN_ADD;
          FC_SUB:  fn = FN_SUB;
          FC_SLT:  fn = FN_SLT;
          FC_AND:  fn = FN_AND;
          FC_OR:   fn = FN_OR;
          FC_XOR:  fn = FN_XOR;
          FC_SLL:  fn = FN_SLL;
          FC_SRL:  fn = FN_SRL;
          FC_MUL:  fn = mulEn ? FN_MUL : FN_ILL;
          default: fn = FN_ILL;
        endcase
      end
      OP_ADD:   fn = FN_ADD;
      OP_SUB:   fn = FN_SUB;
      OP_AND:   fn = FN_AND;
      OP_OR:    fn = FN_OR;
      OP_SLT:   fn = FN_SLT;
      OP_PASSB: fn = FN_PASSB;
      default:  fn = FN_ILL;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, low DATA_W
// bits of the unsigned product; lastStep flags the step that completes it.
module alu_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              lastStep,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] acc, mcand, mplier, partial;
  logic [CNT_W-1:0]  stepCnt;

  assign partial  = mplier[0] ? mcand : '0;
  assign product  = acc + partial;
  assign lastStep = (stepCnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      stepCnt <= '0;
      acc     <= '0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      stepCnt <= '0;
    end else if (step) begin
      acc     <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      stepCnt <= stepCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: decode, single-cycle datapath, registered valid/ready
// output. Define MUL_EN to build the iterative multiplier for funCode 1100.
module ex_alu_unit
  import ex_alu_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int FUN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   aluOp,
  input  logic [FUN_W-1:0]  funCode,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_illegal,
  output logic              busy
);
  localparam int SH_W = $clog2(DATA_W);
`ifdef MUL_EN
  localparam logic MulEn = 1'b1;
`else
  localparam logic MulEn = 1'b0;
`endif

  aluFn_e            fn;
  logic [DATA_W-1:0] aluRes, mulRes;
  logic [SH_W-1:0]   shamt;
  logic              aluIll, idle, accept, loadSingle, mulDone;

  assign fn    = decodeFn(aluOp, funCode, MulEn);
  assign shamt = opB[SH_W-1:0];

  always_comb begin
    aluRes = '0;
    aluIll = 1'b0;
    case (fn)
      FN_ADD:   aluRes = opA + opB;
      FN_SUB:   aluRes = opA - opB;
      FN_AND:   aluRes = opA & opB;
      FN_OR:    aluRes = opA | opB;
      FN_XOR:   aluRes = opA ^ opB;
      FN_SLT:   aluRes = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(opB))};
      FN_SLL:   aluRes = opA << shamt;
      FN_SRL:   aluRes = opA >> shamt;
      FN_PASSB: aluRes = opB;
      FN_MUL:   aluRes = '0;
      default:  aluIll = 1'b1;
    endcase
  end

  // flush squashes any accept in the same cycle
  assign in_ready   = !rst && idle && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign loadSingle = accept && (fn != FN_MUL);

`ifdef MUL_EN
  state_e state, stateNext;
  logic   mulLast, mulStep;

  // Final step waits if the output register is still occupied.
  assign mulStep = (state == ST_MUL) && (!mulLast || !out_valid || out_ready);
  assign mulDone = mulStep && mulLast;
  assign idle    = (state == ST_IDLE);
  assign busy    = (state == ST_MUL);

  always_ff @(posedge clk) begin
    if (rst || flush) state <= ST_IDLE;
    else              state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (accept && fn == FN_MUL) stateNext = ST_MUL;
      ST_MUL:  if (mulDone) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  alu_mul_iter #(.DATA_W(DATA_W)) uMul (
    .clk      (clk),
    .clear    (rst || flush),
    .start    (accept && fn == FN_MUL),
    .step     (mulStep),
    .a        (opA),
    .b        (opB),
    .lastStep (mulLast),
    .product  (mulRes)
  );
`else
  assign mulDone = 1'b0;
  assign mulRes  = '0;
  assign idle    = 1'b1;
  assign busy    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (loadSingle) begin
      out_valid   <= 1'b1;
      out_result  <= aluRes;
      out_zero    <= (aluRes == '0);
      out_illegal <= aluIll;
    end else if (mulDone) begin
      out_valid   <= 1'b1;
      out_result  <= mulRes;
      out_zero    <= (mulRes == '0);
      out_illegal <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit at DATA_W=8; MUL_EN-dependent checks
// follow the same macro as the design.
module tb_ex_alu_unit;
  logic       clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic       out_zero, out_illegal, busy;
  logic [2:0] aluOp;
  logic [3:0] funCode;
  logic [7:0] opA, opB, out_result;

  typedef struct {
    string      nm;
    logic [7:0] res;
    logic       zero;
    logic       ill;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c0, c1;

  ex_alu_unit #(.DATA_W(8), .OP_W(3), .FUN_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .funCode(funCode), .opA(opA), .opB(opB),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: pop an expectation for every result handed downstream.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%h", out_result);
      end else begin
        e = expQ.pop_front();
        if (out_result !== e.res || out_zero !== e.zero || out_illegal !== e.ill) begin
          bad++;
          $display("FAIL %s got=%h z=%b i=%b want=%h z=%b i=%b",
                   e.nm, out_result, out_zero, out_illegal, e.res, e.zero, e.ill);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic send(input string nm, input logic [2:0] op, input logic [3:0] fc,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic ei, input bit push);
    int n = 0;
    aluOp = op; funCode = fc; opA = a; opB = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL %s accept_timeout got=0 want=1", nm);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (push) expQ.push_back('{nm, er, (er == 8'h00), ei});
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluOp = '0; funCode = '0; opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    idle(1);

    // R-type basics, single-cycle latency
    send("r_add", 3'b000, 4'b0000, 8'h0C, 8'h05, 8'h11, 1'b0, 1);
    chk("r_add_latency", out_valid, 1);
    send("r_sub", 3'b000, 4'b0001, 8'h0C, 8'h05, 8'h07, 1'b0, 1);
    send("r_and", 3'b000, 4'b0100, 8'h0C, 8'h05, 8'h04, 1'b0, 1);
    send("r_or",  3'b000, 4'b0101, 8'h0C, 8'h05, 8'h0D, 1'b0, 1);

    // aluOp classes
    send("op_sub",  3'b010, 4'b0000, 8'h05, 8'h05, 8'h00, 1'b0, 1);
    send("op_and",  3'b011, 4'b0000, 8'h05, 8'h05, 8'h05, 1'b0, 1);
    send("op_or",   3'b100, 4'b0000, 8'h05, 8'h05, 8'h05, 1'b0, 1);
    send("op_pass", 3'b110, 4'b0000, 8'h05, 8'h05, 8'h05, 1'b0, 1);
    send("op_ill",  3'b111, 4'b0000, 8'h05, 8'h05, 8'h00, 1'b1, 1);
    send("op_slt",  3'b101, 4'b0000, 8'hFE, 8'hFF, 8'h01, 1'b0, 1);

    // SLT / shifts / illegal funCode
    send("r_slt_neg", 3'b000, 4'b0010, 8'hFF, 8'h01, 8'h01, 1'b0, 1);
    send("r_slt_pos", 3'b000, 4'b0010, 8'h01, 8'hFF, 8'h00, 1'b0, 1);
    send("r_srl",     3'b000, 4'b1001, 8'h80, 8'h0B, 8'h10, 1'b0, 1);
    send("r_sll",     3'b000, 4'b1000, 8'h01, 8'h07, 8'h80, 1'b0, 1);
    send("r_xor",     3'b000, 4'b0110, 8'h0C, 8'h05, 8'h09, 1'b0, 1);
    send("r_ill0011", 3'b000, 4'b0011, 8'h0C, 8'h05, 8'h00, 1'b1, 1);
    idle(2);

`ifdef MUL_EN
    send("mul_13x11", 3'b000, 4'b1100, 8'd13, 8'd11, 8'h8F, 1'b0, 1);
    chk("mul_busy_k", busy, 1);
    chk("mul_in_ready_k", in_ready, 0);
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      chk("mul_busy_mid", busy, 1);
      chk("mul_in_ready_mid", in_ready, 0);
      chk("mul_out_valid_mid", out_valid, 0);
    end
    @(posedge clk); #1;
    chk("mul_busy_done", busy, 0);
    chk("mul_out_valid_done", out_valid, 1);
    send("mul_ffxff", 3'b000, 4'b1100, 8'hFF, 8'hFF, 8'h01, 1'b0, 1);
    idle(12);
`else
    send("mul_ill", 3'b000, 4'b1100, 8'd13, 8'd11, 8'h00, 1'b1, 1);
    chk("mul_ill_valid", out_valid, 1);
    chk("mul_ill_flag", out_illegal, 1);
    chk("mul_ill_busy", busy, 0);
    idle(2);
`endif

    // Backpressure then streaming
    out_ready = 1'b0;
    send("bp_add", 3'b001, 4'b0000, 8'h20, 8'h03, 8'h23, 1'b0, 1);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("bp_result_stable", out_result, 8'h23);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    c0 = cyc;
    send("st_wrap_add", 3'b001, 4'b0000, 8'hFF, 8'h01, 8'h00, 1'b0, 1);
    send("st_wrap_sub", 3'b010, 4'b0000, 8'h00, 8'h01, 8'hFF, 1'b0, 1);
    send("st_xor",      3'b000, 4'b0110, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1);
    send("st_sll",      3'b000, 4'b1000, 8'h03, 8'h06, 8'hC0, 1'b0, 1);
    c1 = cyc;
    chk("stream_cycles", c1 - c0, 4);
    idle(2);

    // Flush of a held output register; result value holds
    out_ready = 1'b0;
    send("fl_add", 3'b001, 4'b0000, 8'h30, 8'h04, 8'h34, 1'b0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_result_hold", out_result, 8'h34);
    out_ready = 1'b1;

    // Flush beats a same-cycle accept
    aluOp = 3'b001; opA = 8'h01; opB = 8'h01; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept", out_valid, 0);

`ifdef MUL_EN
    send("fl_mul", 3'b000, 4'b1100, 8'd13, 8'd11, 8'h00, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_mul_busy", busy, 0);
    chk("flush_mul_in_ready", in_ready, 1);
    idle(10);
    chk("flush_mul_no_result", out_valid, 0);

    send("rst_mul", 3'b000, 4'b1100, 8'd7, 8'd3, 8'h00, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mul_busy", busy, 0);
    idle(10);
    chk("rst_mul_no_result", out_valid, 0);
`endif

    // Reset with a pending result
    out_ready = 1'b0;
    send("rst_add", 3'b001, 4'b0000, 8'h40, 8'h02, 8'h42, 1'b0, 0);
    chk("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_result", out_result, 0);
    chk("rst2_out_zero", out_zero, 0);
    chk("rst2_out_illegal", out_illegal, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_in_ready", in_ready, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(3);

    chk("queue_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
